// File: rtl/fram_portb_arbiter.sv
// rtl/fram_portb_arbiter.sv - banked feature-SRAM port-B arbiter for decoder reads and CU write-back
// Purpose: shares port B of the banked feature SRAM between the decoder read stream and the
//   CU write-back stream. Writes are always queued in a small FIFO and drained in order; a read
//   that hits a queued address waits until that address has been written, and a head write
//   blocked by same-bank reads for STARVE_LIMIT cycles is forced out.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   rd_req/rd_addr             decoder read request (level, held until rd_gnt)
//   rd_gnt                     read issued to BRAM this cycle
//   rd_rvalid/rd_rdata         read data, one cycle after rd_gnt
//   wr_req/wr_addr/wr_wdata    CU write-back; accepted when wr_ready
//   wr_ready, wb_pending       FIFO not full / FIFO not empty
//   bram_addr/wdata/we/en      per-bank BRAM controls, bank i at slice i
//   bram_rdata                 per-bank BRAM read data, 1-cycle latency
// Optional: define FRAM_ARB_STATS_EN to add clr_stats, conflict_cnt and starve_cnt_evt.
module fram_portb_arbiter #(
   parameter int ADDR_WIDTH      = 14,
   parameter int DATA_WIDTH      = 32,
   parameter int BANK_NUM        = 4,
   parameter int BANK_ADDR_WIDTH = 12,
   parameter int WB_DEPTH        = 4,
   parameter int STARVE_LIMIT    = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                rd_req,
   input  logic [ADDR_WIDTH-1:0]               rd_addr,
   output logic                                rd_gnt,
   output logic                                rd_rvalid,
   output logic [DATA_WIDTH-1:0]               rd_rdata,
   input  logic                                wr_req,
   input  logic [ADDR_WIDTH-1:0]               wr_addr,
   input  logic [DATA_WIDTH-1:0]               wr_wdata,
   output logic                                wr_ready,
   output logic                                wb_pending,
   output logic [BANK_NUM*BANK_ADDR_WIDTH-1:0] bram_addr,
   output logic [BANK_NUM*DATA_WIDTH-1:0]      bram_wdata,
   output logic [BANK_NUM-1:0]                 bram_we,
   output logic [BANK_NUM-1:0]                 bram_en,
   input  logic [BANK_NUM*DATA_WIDTH-1:0]      bram_rdata
`ifdef FRAM_ARB_STATS_EN
   ,
   input  logic                                clr_stats,
   output logic [31:0]                         conflict_cnt,
   output logic [31:0]                         starve_cnt_evt
`endif
);

   localparam int BSEL_W = $clog2(BANK_NUM);
   localparam int PTR_W  = $clog2(WB_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int SC_W   = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] fifo_addr_q [WB_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr_d [WB_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [WB_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_d [WB_DEPTH];
   logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, hz_idx;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [SC_W-1:0]       starve_q, starve_d;
   logic                  drained_q, drained_d;
   logic                  rd_rvalid_q, rd_rvalid_d;
   logic [BSEL_W-1:0]     rd_bank_q, rd_bank_d;

   logic                  fifo_empty, fifo_full, hazard, push, wr_issue, rd_go;
   logic                  head_blocked, starve_hit;
   logic [BSEL_W-1:0]     rd_bank, wr_bank;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data;

   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == CNT_W'(WB_DEPTH));
      head_addr  = fifo_addr_q[head_q];
      head_data  = fifo_data_q[head_q];
      rd_bank    = rd_addr[BSEL_W-1:0];
      wr_bank    = head_addr[BSEL_W-1:0];
      push       = wr_req & ~fifo_full;

      // A read must not overtake any queued write to the same word.
      hazard = 1'b0;
      hz_idx = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         hz_idx = head_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (fifo_addr_q[hz_idx] == rd_addr)) begin
            hazard = rd_req;
         end
      end

      // Nothing reaches the BRAM in a reset cycle.
      rd_go    = 1'b0;
      wr_issue = 1'b0;
      if (!rst) begin
         if (state_q == S_RUN) begin
            rd_go    = rd_req & ~hazard;
            wr_issue = ~fifo_empty & (~rd_go | (wr_bank != rd_bank));
         end else begin
            wr_issue = ~fifo_empty;
         end
      end
      head_blocked = ~fifo_empty & ~wr_issue;
      starve_hit   = (state_q == S_RUN) & head_blocked & (starve_q == SC_W'(STARVE_LIMIT - 1));

      state_d   = state_q;
      drained_d = drained_q;
      case (state_q)
         S_RUN: begin
            if (hazard || starve_hit) begin
               state_d   = S_DRAIN;
               drained_d = 1'b0;
            end
         end
         S_DRAIN: begin
            // An empty FIFO also releases DRAIN: the hazarding write may have
            // already left in the cycle that entered DRAIN.
            if (!hazard && (wr_issue || drained_q || fifo_empty)) begin
               state_d   = S_RUN;
               drained_d = 1'b0;
            end else if (wr_issue) begin
               drained_d = 1'b1;
            end
         end
         default: state_d = S_RUN;
      endcase

      starve_d = starve_q;
      if (wr_issue) begin
         starve_d = '0;
      end else if (head_blocked && (starve_q != SC_W'(STARVE_LIMIT - 1))) begin
         starve_d = starve_q + 1'b1;
      end

      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      tail_d      = tail_q;
      head_d      = head_q;
      if (push) begin
         fifo_addr_d[tail_q] = wr_addr;
         fifo_data_d[tail_q] = wr_wdata;
         tail_d              = tail_q + 1'b1;
      end
      if (wr_issue) begin
         head_d = head_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(wr_issue);

      rd_rvalid_d = rd_go;
      rd_bank_d   = rd_bank;

      bram_en    = '0;
      bram_we    = '0;
      bram_addr  = '0;
      bram_wdata = '0;
      if (rd_go) begin
         bram_en[rd_bank] = 1'b1;
         bram_addr[int'(rd_bank)*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = rd_addr[ADDR_WIDTH-1:BSEL_W];
      end
      if (wr_issue) begin
         bram_en[wr_bank] = 1'b1;
         bram_we[wr_bank] = 1'b1;
         bram_addr[int'(wr_bank)*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = head_addr[ADDR_WIDTH-1:BSEL_W];
         bram_wdata[int'(wr_bank)*DATA_WIDTH +: DATA_WIDTH]           = head_data;
      end

      rd_gnt     = rd_go;
      rd_rvalid  = rd_rvalid_q;
      rd_rdata   = rd_rvalid_q ? bram_rdata[int'(rd_bank_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
      wr_ready   = ~fifo_full;
      wb_pending = ~fifo_empty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         starve_q    <= '0;
         drained_q   <= 1'b0;
         rd_rvalid_q <= 1'b0;
         rd_bank_q   <= '0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         starve_q    <= starve_d;
         drained_q   <= drained_d;
         rd_rvalid_q <= rd_rvalid_d;
         rd_bank_q   <= rd_bank_d;
      end
   end

   // Entry storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
   end

`ifdef FRAM_ARB_STATS_EN
   logic [31:0] conflict_q, conflict_d, sevt_q, sevt_d;

   always_comb begin
      conflict_d = conflict_q;
      sevt_d     = sevt_q;
      if (clr_stats) begin
         conflict_d = '0;
         sevt_d     = '0;
      end else begin
         // In RUN a blocked head can only be blocked by a same-bank read.
         if (head_blocked && rd_go && (conflict_q != 32'hFFFF_FFFF)) begin
            conflict_d = conflict_q + 32'd1;
         end
         if (starve_hit && (sevt_q != 32'hFFFF_FFFF)) begin
            sevt_d = sevt_q + 32'd1;
         end
      end
      conflict_cnt   = conflict_q;
      starve_cnt_evt = sevt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_q <= '0;
         sevt_q     <= '0;
      end else begin
         conflict_q <= conflict_d;
         sevt_q     <= sevt_d;
      end
   end
`endif

endmodule

// File: tb/tb_fram_portb_arbiter.sv
// tb/tb_fram_portb_arbiter.sv - self-checking bench for fram_portb_arbiter
module tb_fram_portb_arbiter;
   localparam int AW  = 14;
   localparam int DW  = 32;
   localparam int BN  = 4;
   localparam int BAW = 12;
   localparam int WBD = 4;
   localparam int SL  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, rd_req, wr_req;
   logic [AW-1:0]     rd_addr, wr_addr;
   logic [DW-1:0]     wr_wdata, rd_rdata;
   logic              rd_gnt, rd_rvalid, wr_ready, wb_pending;
   logic [BN*BAW-1:0] bram_addr;
   logic [BN*DW-1:0]  bram_wdata, bram_rdata;
   logic [BN-1:0]     bram_we, bram_en;
`ifdef FRAM_ARB_STATS_EN
   logic              clr_stats = 1'b0;
   logic [31:0]       conflict_cnt, starve_cnt_evt;
`endif

   fram_portb_arbiter dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_wdata(wr_wdata),
      .wr_ready(wr_ready), .wb_pending(wb_pending),
      .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
      .bram_en(bram_en), .bram_rdata(bram_rdata)
`ifdef FRAM_ARB_STATS_EN
      , .clr_stats(clr_stats), .conflict_cnt(conflict_cnt), .starve_cnt_evt(starve_cnt_evt)
`endif
   );

   int checks = 0;
   int errors = 0;

   function automatic logic [DW-1:0] init_word(input int a);
      return 32'(a) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
   endfunction

   // BRAM banks: flat word index {bank address, bank}, never-written words hold init_word.
   logic [DW-1:0] bram_mem [16384];
   bit            bram_wr  [16384];
   always @(posedge clk) begin
      for (int b = 0; b < BN; b++) begin
         if (bram_en[b]) begin
            if (bram_we[b]) begin
               bram_mem[(int'(bram_addr[b*BAW +: BAW]) << 2) | b] <= bram_wdata[b*DW +: DW];
               bram_wr[(int'(bram_addr[b*BAW +: BAW]) << 2) | b]  <= 1'b1;
            end else begin
               bram_rdata[b*DW +: DW] <= bram_wr[(int'(bram_addr[b*BAW +: BAW]) << 2) | b] ?
                  bram_mem[(int'(bram_addr[b*BAW +: BAW]) << 2) | b] :
                  init_word((int'(bram_addr[b*BAW +: BAW]) << 2) | b);
            end
         end
      end
   end

   // Reference model: write queue, memory image and the arbitration rules.
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wentry_t;
   wentry_t       wq[$];
   logic [DW-1:0] ref_mem [int];
   bit            m_drain, m_drained, m_rvalid;
   int            m_starve;
   logic [DW-1:0] m_rdata;
   bit            e_gnt, e_wi, e_haz;
   logic [BN-1:0] e_en, e_we;
   logic [BN*BAW-1:0] e_addr;
   logic [BN*DW-1:0]  e_wdata;

   function automatic logic [DW-1:0] ref_read(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic model_eval();
      e_haz = 1'b0;
      foreach (wq[i]) if (rd_req && wq[i].addr == rd_addr) e_haz = 1'b1;
      e_gnt = 1'b0;
      e_wi  = 1'b0;
      if (!rst) begin
         if (m_drain) e_wi = (wq.size() > 0);
         else begin
            e_gnt = rd_req && !e_haz;
            e_wi  = (wq.size() > 0) && (!e_gnt || (wq[0].addr % BN) != (rd_addr % BN));
         end
      end
      e_en = '0; e_we = '0; e_addr = '0; e_wdata = '0;
      if (e_gnt) begin
         e_en[rd_addr % BN] = 1'b1;
         e_addr[int'(rd_addr % BN)*BAW +: BAW] = BAW'(rd_addr / BN);
      end
      if (e_wi) begin
         e_en[wq[0].addr % BN] = 1'b1;
         e_we[wq[0].addr % BN] = 1'b1;
         e_addr[int'(wq[0].addr % BN)*BAW +: BAW] = BAW'(wq[0].addr / BN);
         e_wdata[int'(wq[0].addr % BN)*DW +: DW]  = wq[0].data;
      end
   endtask

   task automatic model_commit();
      bit blocked, starve_hit;
      int occ;
      if (rst) begin
         wq.delete();
         m_drain = 0; m_drained = 0; m_starve = 0; m_rvalid = 0; m_rdata = '0;
         return;
      end
      occ        = wq.size();
      blocked    = (occ > 0) && !e_wi;
      starve_hit = !m_drain && blocked && (m_starve == SL - 1);
      if (!m_drain) begin
         m_drain = e_haz || starve_hit;
         m_drained = 0;
      end else if (!e_haz && (e_wi || m_drained || occ == 0)) begin
         m_drain = 0;
         m_drained = 0;
      end else if (e_wi) m_drained = 1;
      if (e_wi) m_starve = 0;
      else if (blocked && m_starve < SL - 1) m_starve++;
      m_rvalid = e_gnt;
      m_rdata  = e_gnt ? ref_read(int'(rd_addr)) : '0;
      if (e_wi) begin
         ref_mem[int'(wq[0].addr)] = wq[0].data;
         void'(wq.pop_front());
      end
      if (wr_req && occ < WBD) wq.push_back('{addr: wr_addr, data: wr_wdata});
   endtask

   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_wdata = '0;
      settle(); advance(); settle(); advance();
      rst = 1'b0;
      settle();
      checks++;
      if ({rd_gnt, rd_rvalid, wr_ready, wb_pending, bram_en, bram_we} !== 12'b0010_0000_0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 001000000000",
                  {rd_gnt, rd_rvalid, wr_ready, wb_pending, bram_en, bram_we});
      end
      checks++;
      if (rd_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rd_rdata); end
      checks++;
      if ({bram_addr, bram_wdata} !== '0) begin
         errors++; $display("FAIL reset_bram_bus: got %h expected 0", {bram_addr, bram_wdata});
      end
      advance();
   endtask

   task automatic test_single_write();
      wr_req = 1'b1; wr_addr = 14'h0005; wr_wdata = 32'h1234_5678;
      settle();
      checks++;
      if (bram_we !== 4'b0000) begin errors++; $display("FAIL sw_no_bypass: got we %b expected 0000", bram_we); end
      advance();
      wr_req = 1'b0;
      settle();
      checks++;
      if ({bram_en, bram_we} !== 8'b0010_0010) begin
         errors++; $display("FAIL sw_we: got en/we %b expected 00100010", {bram_en, bram_we});
      end
      checks++;
      if ({bram_addr[BAW +: BAW], bram_wdata[DW +: DW]} !== {12'h001, 32'h1234_5678}) begin
         errors++; $display("FAIL sw_addr_data: got %h/%h expected 001/12345678",
                            bram_addr[BAW +: BAW], bram_wdata[DW +: DW]);
      end
      checks++;
      if (wb_pending !== 1'b1) begin errors++; $display("FAIL sw_pending1: got %b expected 1", wb_pending); end
      advance();
      settle();
      checks++;
      if (wb_pending !== 1'b0) begin errors++; $display("FAIL sw_pending2: got %b expected 0", wb_pending); end
      advance();
   endtask

   task automatic test_parallel();
      logic [DW-1:0] exp_rd;
      wr_req = 1'b1; wr_addr = 14'h0006; wr_wdata = 32'hCAFE_0006;
      settle(); advance();
      wr_req = 1'b0; rd_req = 1'b1; rd_addr = 14'h0004;
      exp_rd = ref_read(4);
      settle();
      checks++;
      if ({rd_gnt, bram_en, bram_we} !== 9'b1_0101_0100) begin
         errors++; $display("FAIL par_issue: got gnt/en/we %b expected 101010100", {rd_gnt, bram_en, bram_we});
      end
      advance();
      rd_req = 1'b0;
      settle();
      checks++;
      if ({rd_rvalid, rd_rdata} !== {1'b1, exp_rd}) begin
         errors++; $display("FAIL par_rdata: got %b/%h expected 1/%h", rd_rvalid, rd_rdata, exp_rd);
      end
      advance();
   endtask

   task automatic test_starvation();
      for (int c = 0; c < 12; c++) begin
         rd_req = 1'b1; rd_addr = 14'h0001;
         wr_req = (c == 0); wr_addr = 14'h0009; wr_wdata = 32'h5555_0009;
         settle();
         checks++;
         if ({rd_gnt, bram_we} !== {(c != 9), (c == 9) ? 4'b0010 : 4'b0000}) begin
            errors++; $display("FAIL starve_cycle%0d: got gnt/we %b/%b expected %b/%b", c, rd_gnt, bram_we,
                               (c != 9), (c == 9) ? 4'b0010 : 4'b0000);
         end
         advance();
      end
      rd_req = 1'b0; wr_req = 1'b0;
      settle(); advance();
   endtask

   task automatic test_raw();
      bit seen_write = 0, granted = 0;
      wr_req = 1'b1; wr_addr = 14'h0010; wr_wdata = 32'hDEAD_BEEF;
      settle(); advance();
      wr_req = 1'b0; rd_req = 1'b1; rd_addr = 14'h0010;
      for (int c = 0; c < 12 && !granted; c++) begin
         settle();
         if (rd_gnt) begin
            granted = 1;
            checks++;
            if (!seen_write) begin errors++; $display("FAIL raw_order: got read before write expected write first"); end
         end
         if (bram_we[0] && bram_addr[BAW-1:0] == 12'h004) seen_write = 1;
         advance();
         if (granted) rd_req = 1'b0;
      end
      checks++;
      if (!granted) begin errors++; $display("FAIL raw_timeout: got no rd_gnt expected grant"); end
      rd_req = 1'b0;
      settle();
      checks++;
      if ({rd_rvalid, rd_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL raw_rdata: got %b/%h expected 1/deadbeef", rd_rvalid, rd_rdata);
      end
      advance();
   endtask

   task automatic test_full();
      int k = 0, first_pop = -1, accept5 = -1;
      rd_req = 1'b1; rd_addr = 14'h0002;
      for (int c = 0; c < 30 && k < 5; c++) begin
         wr_req = 1'b1; wr_addr = AW'(6 + 4 * k); wr_wdata = 32'hF000_0000 | 32'(k);
         settle();
         if (bram_we[2] && first_pop < 0) first_pop = c;
         if (c == 4) begin
            checks++;
            if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", wr_ready); end
         end
         if (wr_ready) begin
            if (k == 4) accept5 = c;
            k++;
         end
         advance();
      end
      wr_req = 1'b0; rd_req = 1'b0;
      checks++;
      if (accept5 < 0 || first_pop < 0 || accept5 <= first_pop) begin
         errors++; $display("FAIL full_fifth: got accept at %0d pop at %0d expected accept after pop", accept5, first_pop);
      end
      for (int c = 0; c < 20; c++) begin
         settle();
         if (!wb_pending) break;
         advance();
      end
      checks++;
      if (wb_pending !== 1'b0) begin errors++; $display("FAIL full_drain: got pending %b expected 0", wb_pending); end
      advance();
      for (int j = 0; j < 5; j++) begin
         rd_req = 1'b1; rd_addr = AW'(6 + 4 * j);
         settle(); advance();
         rd_req = 1'b0;
         settle();
         checks++;
         if ({rd_rvalid, rd_rdata} !== {1'b1, 32'hF000_0000 | 32'(j)}) begin
            errors++; $display("FAIL full_readback%0d: got %b/%h expected 1/%h", j, rd_rvalid, rd_rdata,
                               32'hF000_0000 | 32'(j));
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      rd_req = 1'b1; rd_addr = 14'h0003;
      for (int k = 0; k < 3; k++) begin
         wr_req = 1'b1; wr_addr = AW'(7 + 4 * k); wr_wdata = 32'hBAD0_0000 | 32'(k);
         settle(); advance();
      end
      wr_req = 1'b0; rst = 1'b1;
      settle();
      checks++;
      if ({rd_gnt, bram_we} !== 5'b0) begin
         errors++; $display("FAIL rstmid_during: got gnt/we %b/%b expected 0/0000", rd_gnt, bram_we);
      end
      advance();
      rst = 1'b0; rd_req = 1'b0;
      settle();
      checks++;
      if ({wb_pending, rd_rvalid, bram_we} !== 6'b0) begin
         errors++; $display("FAIL rstmid_after: got pend/rvalid/we %b/%b/%b expected 0/0/0000",
                            wb_pending, rd_rvalid, bram_we);
      end
      advance();
      rd_req = 1'b1; rd_addr = 14'h0007;
      settle(); advance();
      rd_req = 1'b0;
      settle();
      checks++;
      if (rd_rdata !== init_word(7)) begin
         errors++; $display("FAIL rstmid_discard: got %h expected %h", rd_rdata, init_word(7));
      end
      advance();
   endtask

   task automatic test_random();
      bit rd_done = 1;
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         if (!rd_req || rd_done) begin
            rd_req  = ($urandom_range(0, 2) != 0);
            rd_addr = AW'($urandom_range(0, 23));
         end
         wr_req   = $urandom_range(0, 1) == 1;
         wr_addr  = AW'($urandom_range(0, 23));
         wr_wdata = $urandom;
         settle();
         checks++;
         if ({rd_gnt, rd_rvalid, wr_ready, wb_pending} !== {e_gnt, m_rvalid, wq.size() < WBD, wq.size() > 0}) begin
            errors++; $display("FAIL rnd_ctrl@%0d: got %b expected %b", c, {rd_gnt, rd_rvalid, wr_ready, wb_pending},
                               {e_gnt, m_rvalid, wq.size() < WBD, wq.size() > 0});
         end
         checks++;
         if ({bram_en, bram_we} !== {e_en, e_we}) begin
            errors++; $display("FAIL rnd_en_we@%0d: got %b expected %b", c, {bram_en, bram_we}, {e_en, e_we});
         end
         checks++;
         if ({bram_addr, bram_wdata} !== {e_addr, e_wdata}) begin
            errors++; $display("FAIL rnd_bus@%0d: got %h expected %h", c, {bram_addr, bram_wdata}, {e_addr, e_wdata});
         end
         checks++;
         if (rd_rdata !== m_rdata) begin
            errors++; $display("FAIL rnd_rdata@%0d: got %h expected %h", c, rd_rdata, m_rdata);
         end
         rd_done = e_gnt;
         advance();
      end
      rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
      settle(); advance();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_parallel();
      test_starvation();
      test_raw();
      test_full();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000 ns");
      $fatal(1);
   end
endmodule
